// File: rtl/plane_scan.sv
// plane_scan: raster-scans one TILE_W x TILE_H tile, presents each pixel
// coordinate to an external plane interpolator and forwards the result on a
// valid/ready pixel stream with a one-cycle pipeline.
// Optional feature macro: PLANE_SCAN_CLAMP_EN (saturate interp to signed
// 32-bit instead of truncating).
module plane_scan #(
  parameter int unsigned TILE_W = 32,
  parameter int unsigned TILE_H = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] tile_x,
  input  logic [11:0] tile_y,
  output logic [11:0] x_ps,
  output logic [11:0] y_ps,
  input  logic [63:0] interp,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [31:0] pix_z,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int unsigned RW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(TILE_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(TILE_H - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [11:0]   tx_q, tx_d, ty_q, ty_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [11:0]   x_ps_d, y_ps_d, pix_x_d, pix_y_d;
  logic [31:0]   pix_z_d;
  logic          pix_valid_d, busy_d, done_d;
  logic [31:0]   result_c;
  logic          load_c, xfer_c, last_c;

  // Interpolator result conditioning
`ifdef PLANE_SCAN_CLAMP_EN
  logic pos_ovf_c, neg_ovf_c;
  always_comb begin
    pos_ovf_c = !interp[63] && (|interp[62:31]);
    neg_ovf_c = interp[63] && !(&interp[62:31]);
    if (pos_ovf_c)      result_c = 32'h7FFF_FFFF;
    else if (neg_ovf_c) result_c = 32'h8000_0000;
    else                result_c = interp[31:0];
  end
`else
  logic unused_interp_hi;
  assign unused_interp_hi = ^interp[63:32];
  assign result_c = interp[31:0];
`endif

  assign load_c = (state_q == SCAN) && (!pix_valid || pix_ready);
  assign xfer_c = pix_valid && pix_ready;
  assign last_c = (col_q == COL_LAST) && (row_q == ROW_LAST);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    ty_d        = ty_q;
    col_d       = col_q;
    row_d       = row_q;
    x_ps_d      = x_ps;
    y_ps_d      = y_ps;
    pix_x_d     = pix_x;
    pix_y_d     = pix_y;
    pix_z_d     = pix_z;
    pix_valid_d = pix_valid;

    if (xfer_c && !load_c) pix_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_d    = tile_x;
          ty_d    = tile_y;
          col_d   = '0;
          row_d   = '0;
          x_ps_d  = tile_x;
          y_ps_d  = tile_y;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (load_c) begin
          pix_x_d     = x_ps;
          pix_y_d     = y_ps;
          pix_z_d     = result_c;
          pix_valid_d = 1'b1;
          if (last_c) begin
            state_d = DRAIN;
          end else begin
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
            x_ps_d = tx_q + 12'(col_d);
            y_ps_d = ty_q + 12'(row_d);
          end
        end
      end
      DRAIN: begin
        if (xfer_c) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      ty_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      x_ps      <= '0;
      y_ps      <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_z     <= '0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      col_q     <= col_d;
      row_q     <= row_d;
      x_ps      <= x_ps_d;
      y_ps      <= y_ps_d;
      pix_x     <= pix_x_d;
      pix_y     <= pix_y_d;
      pix_z     <= pix_z_d;
      pix_valid <= pix_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_plane_scan.sv
// Directed bench for plane_scan with a 4x4 tile.
module tb_plane_scan;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] tile_x = '0;
  logic [11:0] tile_y = '0;
  logic [11:0] x_ps, y_ps;
  logic [63:0] interp;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [11:0] pix_x, pix_y;
  logic [31:0] pix_z;
  logic        busy, done;

  logic        ovr_en = 1'b0;
  logic [63:0] ovr_val = '0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Stand-in interpolator: x+y unless a fixed value is forced
  assign interp = ovr_en ? ovr_val : (64'(x_ps) + 64'(y_ps));

  plane_scan #(.TILE_W(4), .TILE_H(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .tile_x(tile_x), .tile_y(tile_y), .x_ps(x_ps), .y_ps(y_ps),
    .interp(interp), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_z(pix_z), .busy(busy), .done(done)
  );

  // Runs one tile and checks the 16-pixel stream, stalls, latency and done.
  task automatic scan_tile(input logic [11:0] tx, input logic [11:0] ty,
                           input bit rand_ready, input bit use_fix,
                           input logic [31:0] zfix, input bit restart,
                           input bit start_in_done, input string name);
    int idx, cyc, first_cyc, last_cyc, done_cnt, done_cyc;
    logic held;
    logic [11:0] hx, hy, hxp, hyp, ex, ey;
    logic [31:0] hz, ez;
    @(negedge clock);
    tile_x = tx; tile_y = ty; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_start: busy=%b pix_valid=%b, want busy=1 pix_valid=0", name, busy, pix_valid);
    end
    idx = 0; cyc = 0; first_cyc = -1; last_cyc = -1; done_cnt = 0; done_cyc = -1;
    held = 1'b0; hx = '0; hy = '0; hxp = '0; hyp = '0; hz = '0;
    while (cyc < 400 && !(idx >= 16 && cyc > last_cyc + 2)) begin
      start = (restart && cyc == 5) || (start_in_done && done === 1'b1);
      if (restart && cyc == 5) begin tile_x = 12'd999; tile_y = 12'd999; end
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (held) begin
        checks++;
        if ({pix_valid, pix_x, pix_y, pix_z, x_ps, y_ps} !== {1'b1, hx, hy, hz, hxp, hyp}) begin
          errors++;
          $display("FAIL %s_stall: got v=%b (%0d,%0d,%h) ps=(%0d,%0d), want v=1 (%0d,%0d,%h) ps=(%0d,%0d)",
                   name, pix_valid, pix_x, pix_y, pix_z, x_ps, y_ps, hx, hy, hz, hxp, hyp);
        end
      end
      if (pix_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (pix_ready) begin
          ex = tx + 12'(idx % 4);
          ey = ty + 12'(idx / 4);
          ez = use_fix ? zfix : (32'(ex) + 32'(ey));
          checks++;
          if (idx >= 16 || {pix_x, pix_y, pix_z} !== {ex, ey, ez}) begin
            errors++;
            $display("FAIL %s_pixel%0d: got (%0d,%0d,%h), want (%0d,%0d,%h)",
                     name, idx, pix_x, pix_y, pix_z, ex, ey, ez);
          end
          idx++;
          if (idx == 16) last_cyc = cyc;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hx = pix_x; hy = pix_y; hz = pix_z; hxp = x_ps; hyp = y_ps;
        end
      end else begin
        held = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    pix_ready = 1'b1;
    checks++;
    if (idx != 16) begin
      errors++;
      $display("FAIL %s_count: got %0d pixels, want 16", name, idx);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_cyc + 1) begin
      errors++;
      $display("FAIL %s_done: got %0d pulses at cycle %0d, want 1 at cycle %0d", name, done_cnt, done_cyc, last_cyc + 1);
    end
    if (!rand_ready) begin
      checks++;
      if (first_cyc != 1 || last_cyc != 16) begin
        errors++;
        $display("FAIL %s_latency: got first=%0d last=%0d, want first=1 last=16", name, first_cyc, last_cyc);
      end
    end
    checks++;
    if (busy !== 1'b0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after: busy=%b pix_valid=%b, want 0 0", name, busy, pix_valid);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({busy, done, pix_valid, pix_x, pix_y, pix_z, x_ps, y_ps} !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b v=%b pix=(%0d,%0d,%h) ps=(%0d,%0d), want all 0",
               name, busy, done, pix_valid, pix_x, pix_y, pix_z, x_ps, y_ps);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset_state");
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    scan_tile(12'd32, 12'd64, 1'b0, 1'b0, '0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_stall();
    scan_tile(12'd32, 12'd64, 1'b1, 1'b0, '0, 1'b0, 1'b0, "stall");
  endtask

  task automatic test_wrap();
    scan_tile(12'd4094, 12'd4094, 1'b0, 1'b0, '0, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_clamp();
    logic [31:0] e_pos, e_neg;
`ifdef PLANE_SCAN_CLAMP_EN
    e_pos = 32'h7FFF_FFFF;
    e_neg = 32'h8000_0000;
`else
    e_pos = 32'h0000_0000;
    e_neg = 32'h0000_0000;
`endif
    ovr_en = 1'b1;
    ovr_val = 64'h0000_0001_0000_0000;
    scan_tile(12'd0, 12'd0, 1'b0, 1'b1, e_pos, 1'b0, 1'b0, "clamp_pos");
    ovr_val = 64'hFFFF_FF00_0000_0000;
    scan_tile(12'd0, 12'd0, 1'b0, 1'b1, e_neg, 1'b0, 1'b0, "clamp_neg");
    ovr_val = 64'hFFFF_FFFF_FFFF_FFFB;
    scan_tile(12'd0, 12'd0, 1'b0, 1'b1, 32'hFFFF_FFFB, 1'b0, 1'b0, "inrange_neg");
    ovr_val = 64'h0000_0000_7FFF_FFFF;
    scan_tile(12'd0, 12'd0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, "inrange_max");
    ovr_en = 1'b0;
  endtask

  task automatic test_restart_ignored();
    scan_tile(12'd100, 12'd200, 1'b0, 1'b0, '0, 1'b1, 1'b1, "restart");
  endtask

  task automatic test_reset_mid();
    int n, cyc, dn;
    @(negedge clock);
    tile_x = 12'd10; tile_y = 12'd20; start = 1'b1; pix_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 50) begin
      if (pix_valid === 1'b1) n++;
      @(posedge clock); #1;
      cyc++;
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL reset_mid_progress: got %0d pixels, want 5", n);
    end
    reset_n = 1'b0;
    #1;
    check_zero("reset_mid_abort");
    dn = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (done === 1'b1) dn++;
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      if (done === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", dn);
    end
    check_zero("reset_mid_idle");
    scan_tile(12'd32, 12'd64, 1'b0, 1'b0, '0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_clamp();
    test_restart_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plane_scan.md
PLANE_SCAN -- requirements
Module: plane_scan

Interface
REQ-001 Parameter TILE_W, default 32, tile width in pixels; power of two, 1..64.
REQ-002 Parameter TILE_H, default 32, tile height in pixels; power of two, 1..64.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to scan a tile.
- tile_x  input  12  tile origin X, sampled on accepted start.
- tile_y  input  12  tile origin Y, sampled on accepted start.
- x_ps  output  12  pixel X presented to the plane interpolator.
- y_ps  output  12  pixel Y presented to the plane interpolator.
- interp  input  64  signed interpolator result for (x_ps, y_ps), combinational, same cycle.
- pix_valid  output  1  output pixel valid.
- pix_ready  input  1  downstream accepts pixel.
- pix_x  output  12  X of output pixel.
- pix_y  output  12  Y of output pixel.
- pix_z  output  32  interpolated value of output pixel.
- busy  output  1  high outside IDLE.
- done  output  1  one-cycle pulse, tile complete.

Function
REQ-004 The FSM SHALL have four states: IDLE, SCAN, DRAIN and DONE.
REQ-005 In IDLE, start SHALL latch tile_x/tile_y, clear col/row counters and move to SCAN; start outside IDLE SHALL be ignored.
REQ-006 In SCAN, x_ps SHALL equal tile_x+col and y_ps SHALL equal tile_y+row, both registered and modulo 4096 (wrap, no error).
REQ-007 The load condition SHALL be state==SCAN && (!pix_valid || pix_ready).
REQ-008 On load, {pix_x, pix_y, pix_z} SHALL capture {x_ps, y_ps, result}, pix_valid SHALL be set, and the coordinate SHALL advance: raster order, col fastest, col wraps to 0 and row increments at TILE_W-1.
REQ-009 Latency: a coordinate on x_ps/y_ps in cycle N SHALL appear on the pix_* outputs with pix_valid in cycle N+1; at pix_ready=1 throughput SHALL be one pixel per clock.
REQ-010 A load of pixel (TILE_W-1, TILE_H-1) SHALL move SCAN to DRAIN, and the coordinate SHALL NOT advance.
REQ-011 With pix_valid=1 and pix_ready=0, pix_* and x_ps/y_ps SHALL hold stable, with no pixel lost or duplicated.
REQ-012 In DRAIN, pix_valid && pix_ready SHALL clear pix_valid and move to DONE; a transfer with no new load in any other state SHALL also clear pix_valid.
REQ-013 DONE SHALL assert done for exactly one cycle, then return to IDLE; start in that cycle SHALL be ignored.
REQ-014 busy SHALL be high in SCAN, DRAIN and DONE.
REQ-015 Each tile SHALL emit exactly TILE_W*TILE_H pixels.

Reset
REQ-016 While reset_n=0, the block SHALL be in IDLE with busy=0, done=0, pix_valid=0, and pix_x, pix_y, pix_z, x_ps, y_ps, col and row all 0.
REQ-017 Reset asserted mid-scan SHALL abort immediately; any pending pixel SHALL be discarded and no done SHALL be issued.

Configuration
REQ-018 Macro PLANE_SCAN_CLAMP_EN defined: result SHALL be interp saturated to signed 32-bit (>2^31-1 gives 0x7FFFFFFF; <-2^31 gives 0x80000000).
REQ-019 Macro PLANE_SCAN_CLAMP_EN undefined: result SHALL be interp[31:0], truncated.

Verification
REQ-020 TILE_W=TILE_H=4, tile_x=32, tile_y=64, interp=x_ps+y_ps, pix_ready=1 -> 16 pixels on consecutive cycles, first (32,64,96), last (35,67,102), done one cycle after last transfer.
REQ-021 Same setup, pix_ready toggled pseudo-randomly -> identical 16-pixel sequence, pix_* stable whenever stalled.
REQ-022 tile_x=4094, TILE_W=4 -> pix_x sequence 4094, 4095, 0, 1.
REQ-023 interp=64'h0000_0001_0000_0000 -> pix_z=0x7FFFFFFF with the macro, 0x00000000 without it; interp=-2^40 -> 0x80000000 with the macro.
REQ-024 start re-pulsed mid-scan, and reset_n dropped on pixel 5 -> scan unaffected by the start, then all outputs zero and no done; a new start after reset gives a full tile.
